ram_master: RTL and testbench
=============================

Name: ram_master

Overview:
- Bus initiator that drives the asynchronous-strobe RAM used by the MC14500B system.
- RAM interface it drives: write strobe, address, data_in, data_out. The RAM writes on the rising edge of write. Its read output is transparent while write is low and holds while write is high.
- Converts clocked command handshakes from the control sequencer into correctly timed RAM cycles.
- Supports single accesses and fixed-length bursts: read streaming, or write-fill of one value.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width; address space is 2**ADDR_WIDTH words.
- LEN_WIDTH, 4, width of the burst length field (beats = len+1).
- SETUP_CYCLES, 1, clocks that address/data are stable with write low before the strobe rises (>=1).
- READ_WAIT, 1, clocks from address change to read sample (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  master idle, command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write/fill, 0=read
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  LEN_WIDTH  beats minus one
- cmd_wdata  in  DATA_WIDTH  value written to every beat of a write burst
- rsp_valid  out  1  one-clock pulse per read beat, or once at write-burst completion
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid (0 for writes)
- busy  out  1  command in progress
- mem_write  out  1  RAM write strobe
- mem_address  out  ADDR_WIDTH  RAM address
- mem_data_in  out  DATA_WIDTH  RAM write data
- mem_data_out  in  DATA_WIDTH  RAM read data

Behaviour:
- Clock and reset: single clock domain clk; reset is asynchronous, active-low (rst_n).
- Registered outputs: all outputs are registered except cmd_ready, which equals (state==IDLE).
- Reset values:
  - state IDLE, busy 0, rsp_valid 0, rsp_rdata 0.
  - mem_write 0, mem_address 0, mem_data_in 0.
  - beat and wait counters 0.
- States: IDLE, SETUP, STROBE, HOLD, RWAIT, DONE.
- IDLE:
  - On accept, latch write/len/wdata.
  - Set mem_address=cmd_addr, busy=1, beat counter=cmd_len, wait counter loaded.
  - Go to SETUP if write, else RWAIT.
- Write path:
  - SETUP holds mem_write=0 for SETUP_CYCLES with mem_address/mem_data_in stable.
  - STROBE drives mem_write=1 for exactly one clock; the RAM writes on that rising edge.
  - HOLD drives mem_write=0 for one clock with address/data unchanged.
  - From HOLD: if beat counter==0 go to DONE; else decrement, address+1, go to SETUP.
- Read path:
  - RWAIT waits READ_WAIT clocks after the address is driven.
  - At the end of the wait, sample mem_data_out into rsp_rdata and pulse rsp_valid.
  - If beat counter==0 go to DONE; else decrement, address+1, reload the wait counter, stay in RWAIT.
  - Throughput is 1 beat per READ_WAIT clocks. No backpressure on rsp.
- DONE:
  - Lasts one clock; busy=0 on exit. For write commands, pulse rsp_valid here (rsp_rdata=0).
  - Return to IDLE; cmd_ready rises the following clock.
- Address arithmetic: modulo 2**ADDR_WIDTH; a burst wraps from max to 0 with no error.
- Strobe invariants:
  - mem_write is never high in two consecutive clocks.
  - mem_write is never high while mem_address or mem_data_in changes.
  - mem_write is never high in read states.
- cmd_* inputs are ignored outside IDLE; cmd_valid held during busy has no effect.
- Reset mid-operation:
  - All outputs and state return to their reset values immediately; mem_write drops asynchronously.
  - A beat interrupted in STROBE may or may not have been written. The bench must not check that word.
- Single-beat latency:
  - Write, cmd accept to rsp_valid: SETUP_CYCLES+3 clocks.
  - Read, cmd accept to rsp_valid: READ_WAIT clocks.

Decomposition:
- Package mc_ram_pkg:
  - state_t enum (IDLE, SETUP, STROBE, HOLD, RWAIT, DONE).
  - mem_cmd_t struct {write, addr, len, wdata}, parameterised by widths through localparam defaults.
- One sub-module, ram_wait_counter: a loadable down-counter with a done flag, used for both SETUP and RWAIT timing.

Test Plan:
- Single write then read back: write addr 0x10 data 0xA5 (len 0), then read addr 0x10 -> mem_write high exactly 1 clock; rsp_rdata=0xA5; write latency SETUP_CYCLES+3.
- Fill burst: write addr 0x20 len 3 data 0x3C -> four strobes at 0x20..0x23, each separated by SETUP+HOLD; one rsp_valid at end; reads of 0x1F and 0x24 unchanged.
- Read burst with wrap: preload 0xFE=0x11, 0xFF=0x22, 0x00=0x33; read addr 0xFE len 2 -> three rsp_valid pulses returning 0x11, 0x22, 0x33.
- Command during busy: assert cmd_valid with other fields while a burst runs -> cmd_ready=0, command ignored, accepted only after DONE.
- Reset mid-burst: assert rst_n low during 2nd beat of a 4-beat fill -> mem_write=0 the same instant; all outputs at reset values; next command executes normally.
- Strobe-invariant assertion across randomized commands -> no two-clock mem_write high; address/data stable during and one clock after every strobe.

Source files
------------

// File: rtl/mc_ram_pkg.sv
// rtl/mc_ram_pkg.sv - shared types and widths for the MC14500B RAM master
package mc_ram_pkg;

  localparam int MC_DATA_WIDTH = 8;
  localparam int MC_ADDR_WIDTH = 8;
  localparam int MC_LEN_WIDTH  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RWAIT,
    DONE
  } state_t;

  // Live command register: addr walks through the burst, len counts down the remaining beats.
  typedef struct packed {
    logic                     write;
    logic [MC_ADDR_WIDTH-1:0] addr;
    logic [MC_LEN_WIDTH-1:0]  len;
    logic [MC_DATA_WIDTH-1:0] wdata;
  } mem_cmd_t;

  // Counter width large enough to hold the longer of the two wait reload values (n-1).
  function automatic int wait_cnt_width(input int setup_cycles, input int read_wait);
    int longest;
    longest = (setup_cycles > read_wait) ? setup_cycles : read_wait;
    return (longest <= 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/ram_wait_counter.sv
// rtl/ram_wait_counter.sv - loadable down-counter timing SETUP and RWAIT phases
module ram_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority; otherwise count down while enabled, parking at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/ram_master.sv
// rtl/ram_master.sv - command-driven initiator for the asynchronous-strobe RAM
module ram_master
  import mc_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = MC_DATA_WIDTH,
  parameter int ADDR_WIDTH   = MC_ADDR_WIDTH,
  parameter int LEN_WIDTH    = MC_LEN_WIDTH,
  parameter int SETUP_CYCLES = 1,
  parameter int READ_WAIT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int CNT_W = wait_cnt_width(SETUP_CYCLES, READ_WAIT);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);

  state_t                state_q, state_d;
  mem_cmd_t              cmd_q, cmd_d;
  logic                  mem_write_q, mem_write_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  busy_q, busy_d;

  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_load_value;
  logic                  cnt_en;
  logic                  cnt_done;

  ram_wait_counter #(
    .W (CNT_W)
  ) u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .en         (cnt_en),
    .done       (cnt_done)
  );

  // Next-state and next-output logic; the strobe is only ever requested on the SETUP->STROBE step.
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    mem_write_d    = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    busy_d         = busy_q;
    cnt_load       = 1'b0;
    cnt_load_value = SETUP_LOAD;
    cnt_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = cmd_addr;
          cmd_d.len   = cmd_len;
          cmd_d.wdata = cmd_wdata;
          busy_d      = 1'b1;
          cnt_load    = 1'b1;
          if (cmd_write) begin
            cnt_load_value = SETUP_LOAD;
            state_d        = SETUP;
          end else begin
            cnt_load_value = READ_LOAD;
            state_d        = RWAIT;
          end
        end
      end

      SETUP: begin
        if (cnt_done) begin
          mem_write_d = 1'b1;
          state_d     = STROBE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      STROBE: begin
        state_d = HOLD;
      end

      HOLD: begin
        if (cmd_q.len == '0) begin
          state_d = DONE;
        end else begin
          cmd_d.len      = cmd_q.len - MC_LEN_WIDTH'(1);
          cmd_d.addr     = cmd_q.addr + MC_ADDR_WIDTH'(1);
          cnt_load       = 1'b1;
          cnt_load_value = SETUP_LOAD;
          state_d        = SETUP;
        end
      end

      RWAIT: begin
        if (cnt_done) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_data_out;
          if (cmd_q.len == '0) begin
            state_d = DONE;
          end else begin
            cmd_d.len      = cmd_q.len - MC_LEN_WIDTH'(1);
            cmd_d.addr     = cmd_q.addr + MC_ADDR_WIDTH'(1);
            cnt_load       = 1'b1;
            cnt_load_value = READ_LOAD;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (cmd_q.write) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset drops the strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mem_write_q <= mem_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = busy_q;
  assign mem_write   = mem_write_q;
  assign mem_address = cmd_q.addr;
  assign mem_data_in = cmd_q.wdata;

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - self-checking bench for ram_master with a strobe-driven RAM model
module tb_ram_master;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int LW = 4;
  localparam int SC = 1;
  localparam int RW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ram [256];
  logic [7:0]  model_mem [256];
  logic [7:0]  rd_hold = 8'h00;
  logic [15:0] strobe_q [$];
  logic        mon_en = 1'b0;
  logic        prev_we = 1'b0;
  logic [7:0]  prev_addr = 8'h00;
  logic [7:0]  prev_data = 8'h00;

  always #5 clk = ~clk;

  ram_master #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .LEN_WIDTH    (LW),
    .SETUP_CYCLES (SC),
    .READ_WAIT    (RW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // RAM: writes on the rising strobe, read path transparent while strobe low, held while high.
  always @(posedge mem_write) begin
    rd_hold = ram[mem_address];
    ram[mem_address] = mem_data_in;
  end
  assign mem_data_out = mem_write ? rd_hold : ram[mem_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe monitor: single-clock strobes, address/data frozen around each strobe.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (mem_write) begin
        strobe_q.push_back({mem_address, mem_data_in});
        chk("strobe_single_clk", 32'(prev_we), 32'd0);
      end
      if (mem_write || prev_we) begin
        chk("strobe_addr_data_stable", 32'({mem_address, mem_data_in}), 32'({prev_addr, prev_data}));
      end
    end
    prev_we   <= rst_n ? mem_write : 1'b0;
    prev_addr <= mem_address;
    prev_data <= mem_data_in;
  end

  task automatic exec_cmd(input logic w, input logic [7:0] a, input logic [3:0] l,
                          input logic [7:0] d, input logic poke,
                          output int nrsp, output int lat0, output logic [7:0] rd0);
    int         exp_edge [$];
    logic [7:0] exp_data [$];
    int         edge_n;
    int         wait_n;
    logic [7:0] ad;
    logic       fin;
    nrsp = 0;
    lat0 = -1;
    rd0  = 8'h00;
    if (w) begin
      exp_edge.push_back((int'(l) + 1) * (SC + 2) + 1);
      exp_data.push_back(8'h00);
    end else begin
      for (int i = 0; i <= int'(l); i++) begin
        ad = a + 8'(i);
        exp_edge.push_back(RW * (i + 1));
        exp_data.push_back(model_mem[ad]);
      end
    end
    strobe_q.delete();
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_wdata = d;
    wait_n = 0;
    while (!cmd_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (poke) begin
      cmd_write = 1'b1;
      cmd_addr  = 8'h60;
      cmd_len   = 4'd0;
      cmd_wdata = 8'hEE;
      chk("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
    end else begin
      cmd_valid = 1'b0;
    end
    edge_n = 0;
    fin = 1'b0;
    while (!fin && edge_n < 300) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      if (rsp_valid) begin
        if (nrsp < exp_edge.size()) begin
          chk("rsp_edge", 32'(edge_n), 32'(exp_edge[nrsp]));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_data[nrsp]));
        end
        if (nrsp == 0) begin
          lat0 = edge_n;
          rd0  = rsp_rdata;
        end
        nrsp++;
      end
      if (poke && busy) chk("cmd_ready_while_busy", 32'(cmd_ready), 32'd0);
      if (cmd_ready) fin = 1'b1;
    end
    chk("cmd_complete", 32'(fin), 32'd1);
    chk("rsp_count", 32'(nrsp), 32'(exp_edge.size()));
    if (w) begin
      chk("strobe_count", 32'(strobe_q.size()), 32'(int'(l) + 1));
      for (int i = 0; i < strobe_q.size() && i <= int'(l); i++) begin
        ad = a + 8'(i);
        chk("strobe_addr_data", 32'(strobe_q[i]), 32'({ad, d}));
      end
      for (int i = 0; i <= int'(l); i++) begin
        ad = a + 8'(i);
        model_mem[ad] = d;
      end
    end else begin
      chk("strobe_count_read", 32'(strobe_q.size()), 32'd0);
    end
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [3:0] l;
    logic [7:0] d;
    int         exp_nrsp;
    int         exp_lat;
    logic [7:0] exp_rd0;
  } vec_t;

  vec_t tbl [10];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         nrsp;
    int         lat0;
    logic [7:0] rd0;
    int         n_str;

    for (int i = 0; i < 256; i++) begin
      ram[i]       = 8'(i) ^ 8'h5A;
      model_mem[i] = 8'(i) ^ 8'h5A;
    end

    tbl[0] = '{1'b1, 8'h10, 4'd0, 8'hA5, 1, SC + 3,          8'h00};
    tbl[1] = '{1'b0, 8'h10, 4'd0, 8'h00, 1, RW,              8'hA5};
    tbl[2] = '{1'b1, 8'h20, 4'd3, 8'h3C, 1, 4 * (SC + 2) + 1, 8'h00};
    tbl[3] = '{1'b0, 8'h1F, 4'd0, 8'h00, 1, RW,              8'h45};
    tbl[4] = '{1'b0, 8'h24, 4'd0, 8'h00, 1, RW,              8'h7E};
    tbl[5] = '{1'b0, 8'h20, 4'd3, 8'h00, 4, RW,              8'h3C};
    tbl[6] = '{1'b1, 8'hFE, 4'd0, 8'h11, 1, SC + 3,          8'h00};
    tbl[7] = '{1'b1, 8'hFF, 4'd0, 8'h22, 1, SC + 3,          8'h00};
    tbl[8] = '{1'b1, 8'h00, 4'd0, 8'h33, 1, SC + 3,          8'h00};
    tbl[9] = '{1'b0, 8'hFE, 4'd2, 8'h00, 3, RW,              8'h11};

    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_mem_address", 32'(mem_address), 32'd0);
    chk("reset_mem_data_in", 32'(mem_data_in), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      exec_cmd(tbl[i].w, tbl[i].a, tbl[i].l, tbl[i].d, 1'b0, nrsp, lat0, rd0);
      chk($sformatf("tbl%0d_nrsp", i), 32'(nrsp), 32'(tbl[i].exp_nrsp));
      chk($sformatf("tbl%0d_latency", i), 32'(lat0), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_rdata0", i), 32'(rd0), 32'(tbl[i].exp_rd0));
    end

    exec_cmd(1'b1, 8'h50, 4'd2, 8'h99, 1'b1, nrsp, lat0, rd0);
    exec_cmd(1'b1, 8'h60, 4'd0, 8'hEE, 1'b0, nrsp, lat0, rd0);
    chk("held_cmd_latency", 32'(lat0), 32'(SC + 3));
    exec_cmd(1'b0, 8'h50, 4'd2, 8'h00, 1'b0, nrsp, lat0, rd0);
    exec_cmd(1'b0, 8'h60, 4'd0, 8'h00, 1'b0, nrsp, lat0, rd0);
    chk("held_cmd_readback", 32'(rd0), 32'hEE);

    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h40;
    cmd_len   = 4'd3;
    cmd_wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_str = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (mem_write) begin
        n_str++;
        if (n_str == 2) break;
      end
    end
    chk("second_strobe_reached", 32'(n_str), 32'd2);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("midrst_mem_address", 32'(mem_address), 32'd0);
    chk("midrst_mem_data_in", 32'(mem_data_in), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    model_mem[8'h40] = 8'h77;
    exec_cmd(1'b1, 8'h41, 4'd0, 8'h5C, 1'b0, nrsp, lat0, rd0);
    chk("post_reset_write_latency", 32'(lat0), 32'(SC + 3));
    exec_cmd(1'b0, 8'h40, 4'd3, 8'h00, 1'b0, nrsp, lat0, rd0);
    chk("post_reset_read_rd0", 32'(rd0), 32'h77);

    for (int k = 0; k < 40; k++) begin
      exec_cmd(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 3)),
               8'($urandom), 1'b0, nrsp, lat0, rd0);
    end

    for (int i = 0; i < 256; i++) begin
      if (i < 8'h41 || i > 8'h41) begin
        if (ram[i] !== model_mem[i]) chk($sformatf("final_ram_%0h", i), 32'(ram[i]), 32'(model_mem[i]));
      end
    end
    chk("final_ram_fill_20", 32'(ram[8'h23]), 32'(model_mem[8'h23]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
